sram_1rw1r_ctrl: RTL and testbench

SRAM_1RW1R_CTRL -- requirements
Module: sram_1rw1r_ctrl

---
 rtl/sram_1rw1r_ctrl_if.sv | 39 +++
 rtl/sram_1rw1r_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_1rw1r_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw1r_ctrl_if.sv
// Requester-side bus for the 1RW/1R SRAM controller.
// Port A is a read/write requester and port B is a read-only requester.
// master = requester side, slave = controller side.
interface sram_1rw1r_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    // Port A: read/write requester
    logic                  a_valid;
    logic                  a_ready;
    logic                  a_we;
    logic [NUM_WMASKS-1:0] a_wmask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    // Port B: read-only requester
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    modport master (
        output a_valid, a_we, a_wmask, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_valid, b_addr,
        input  b_ready, b_rvalid, b_rdata
    );

    modport slave (
        input  a_valid, a_we, a_wmask, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_valid, b_addr,
        output b_ready, b_rvalid, b_rdata
    );
endinterface

// File: rtl/sram_1rw1r_ctrl.sv
// Controller for a 1RW + 1R synchronous SRAM macro.
// After reset it optionally zero-fills the array (INIT), then serves
// port A (read/write) on SRAM port 0 and port B (read) on SRAM port 1.
// All macro control/address/data pins come straight from flops. Read data
// is returned two edges after accept with a one-cycle rvalid pulse.
module sram_1rw1r_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,

    sram_1rw1r_ctrl_if.slave      bus,

    // SRAM port 0 (read/write)
    output logic                  clk0,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    // SRAM port 1 (read only)
    output logic                  clk1,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,

    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    localparam state_t              RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
    // Counter value of the final word; the counter steps past it to 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] LAST_WORD   = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_STEP    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  a_ready;
    logic                  b_ready;
    logic                  a_acc;
    logic                  b_acc;
    logic                  collide;
    logic                  a_rd_p1;
    logic                  a_rd_p2;
    logic                  b_rd_p1;
    logic                  b_rd_p2;
    logic                  a_rvalid;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] b_rdata;

    assign clk0 = clk;
    assign clk1 = clk;

    // A write to the address B wants this cycle blocks B so B never reads
    // the word on the same edge the macro writes it.
    assign collide = bus.a_valid & bus.a_we & (bus.a_addr == bus.b_addr);
    assign a_acc   = bus.a_valid & a_ready;
    assign b_acc   = bus.b_valid & b_ready;

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.a_rvalid = a_rvalid;
    assign bus.a_rdata  = a_rdata;
    assign bus.b_rvalid = b_rvalid;
    assign bus.b_rdata  = b_rdata;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake readies.
    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == LAST_WORD) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // init_done is low only while reset is held, which keeps
                // both ports closed during reset when INIT is skipped.
                a_ready = init_done;
                b_ready = init_done & ~collide;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // init_done tracks the registered state but is forced low by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_done <= 1'b0;
        end else begin
            init_done <= (state_next == ST_IDLE);
        end
    end

    // SRAM port 0 drive: zero-fill sweep during INIT, port A accepts in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
            cnt    <= '0;
        end else if (state == ST_INIT) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            wmask0 <= '1;
            addr0  <= cnt[ADDR_WIDTH-1:0];
            din0   <= '0;
            cnt    <= cnt + CNT_STEP;
        end else if (a_acc) begin
            csb0   <= 1'b0;
            web0   <= ~bus.a_we;
            wmask0 <= bus.a_we ? bus.a_wmask : {NUM_WMASKS{1'b1}};
            addr0  <= bus.a_addr;
            din0   <= bus.a_wdata;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
        end
    end

    // SRAM port 1 drive: port B read accepts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csb1  <= 1'b1;
            addr1 <= '0;
        end else begin
            csb1 <= ~b_acc;
            if (b_acc) begin
                addr1 <= bus.b_addr;
            end
        end
    end

    // Read-return pipeline for both ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rd_p1  <= 1'b0;
            a_rd_p2  <= 1'b0;
            b_rd_p1  <= 1'b0;
            b_rd_p2  <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            // p1: read request launched to the macro pins
            a_rd_p1  <= a_acc & ~bus.a_we;
            b_rd_p1  <= b_acc;
            // p2: macro samples the request; dout valid after this edge
            a_rd_p2  <= a_rd_p1;
            b_rd_p2  <= b_rd_p1;
            // output: capture dout and pulse rvalid for one cycle
            a_rvalid <= a_rd_p2;
            b_rvalid <= b_rd_p2;
            if (a_rd_p2) begin
                a_rdata <= dout0;
            end
            if (b_rd_p2) begin
                b_rdata <= dout1;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Directed bench for sram_1rw1r_ctrl with a behavioural 1RW/1R SRAM model.
module tb_sram_1rw1r_ctrl;

    logic        clk;
    logic        rstn;
    logic        clk0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        clk1;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];

    sram_1rw1r_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

    sram_1rw1r_ctrl #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .NUM_WMASKS(4),
        .INIT_ZERO (1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .clk0     (clk0),
        .csb0     (csb0),
        .web0     (web0),
        .wmask0   (wmask0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0),
        .clk1     (clk1),
        .csb1     (csb1),
        .addr1    (addr1),
        .dout1    (dout1),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: garbage-filled so the zero-fill is observable.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_A5A5;
        dout0 = 32'h0;
        dout1 = 32'h0;
    end

    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int l = 0; l < 4; l++) begin
                    if (wmask0[l]) mem[addr0][l*8 +: 8] <= din0[l*8 +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [3:0] m,
                           input logic [7:0] a, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_we    = we;
        bus.a_wmask = m;
        bus.a_addr  = a;
        bus.a_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] a);
        bus.b_valid = v;
        bus.b_addr  = a;
    endtask

    initial begin
        rstn = 1'b0;
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b0, 8'h00);

        // Reset values
        repeat (3) step();
        check("rst_csb0",      64'(csb0),       64'(1'b1));
        check("rst_web0",      64'(web0),       64'(1'b1));
        check("rst_csb1",      64'(csb1),       64'(1'b1));
        check("rst_wmask0",    64'(wmask0),     64'(4'h0));
        check("rst_addr0",     64'(addr0),      64'(8'h00));
        check("rst_din0",      64'(din0),       64'(32'h0));
        check("rst_addr1",     64'(addr1),      64'(8'h00));
        check("rst_a_rvalid",  64'(bus.a_rvalid), 64'(1'b0));
        check("rst_b_rvalid",  64'(bus.b_rvalid), 64'(1'b0));
        check("rst_a_rdata",   64'(bus.a_rdata),  64'(32'h0));
        check("rst_b_rdata",   64'(bus.b_rdata),  64'(32'h0));
        check("rst_init_done", 64'(init_done),  64'(1'b0));
        check("rst_a_ready",   64'(bus.a_ready),  64'(1'b0));
        check("rst_b_ready",   64'(bus.b_ready),  64'(1'b0));

        // Zero-fill sweep: one full-mask zero write per edge, 0..255
        rstn = 1'b1;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            check("init_write", {27'h0, csb0, web0, wmask0, addr0, din0},
                  {27'h0, 1'b0, 1'b0, 4'hF, 8'(i), 32'h0});
            check("init_done_seq", 64'(init_done), 64'(i == 255));
            check("init_ready", 64'({bus.a_ready, bus.b_ready}),
                  64'((i == 255) ? 2'b11 : 2'b00));
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        step();
        check("post_init_csb0",   64'(csb0),   64'(1'b1));
        check("post_init_wmask0", 64'(wmask0), 64'(4'h0));
        check("post_init_addr0",  64'(addr0),  64'(8'hFF));

        // Read 0x7F after zero-fill
        drive_a(1'b1, 1'b0, 4'h0, 8'h7F, 32'h0);
        step();
        check("rd7f_pins", {56'h0, csb0, web0, wmask0, 2'b00}, {56'h0, 1'b0, 1'b1, 4'hF, 2'b00});
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        check("rd7f_rv_t0", 64'(bus.a_rvalid), 64'(1'b0));
        step();
        check("rd7f_rv_t1", 64'(bus.a_rvalid), 64'(1'b0));
        step();
        check("rd7f_rv_t2", 64'(bus.a_rvalid), 64'(1'b1));
        check("rd7f_data",  64'(bus.a_rdata),  64'(32'h0));
        step();
        check("rd7f_rv_t3", 64'(bus.a_rvalid), 64'(1'b0));

        // Masked write then read-back
        drive_a(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF);
        step();
        check("wr10_pins", {27'h0, csb0, web0, wmask0, addr0, din0},
              {27'h0, 1'b0, 1'b0, 4'hF, 8'h10, 32'hDEAD_BEEF});
        drive_a(1'b1, 1'b1, 4'h5, 8'h10, 32'h1122_3344);
        step();
        check("wr10m_wmask", 64'(wmask0), 64'(4'h5));
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        step();
        check("idle_pins", {27'h0, csb0, web0, wmask0, addr0, din0},
              {27'h0, 1'b1, 1'b1, 4'h0, 8'h10, 32'h1122_3344});
        check("wr_no_rv1", 64'(bus.a_rvalid), 64'(1'b0));
        step();
        check("wr_no_rv2", 64'(bus.a_rvalid), 64'(1'b0));
        drive_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        step();
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        step();
        check("mask_rv_t1", 64'(bus.a_rvalid), 64'(1'b0));
        step();
        check("mask_rv_t2", 64'(bus.a_rvalid), 64'(1'b1));
        check("mask_data",  64'(bus.a_rdata),  64'(32'hDE22_BE44));

        // Back-to-back reads of 0x01..0x03
        drive_a(1'b1, 1'b1, 4'hF, 8'h01, 32'h0000_00A1);
        step();
        drive_a(1'b1, 1'b1, 4'hF, 8'h02, 32'h0000_00B2);
        step();
        drive_a(1'b1, 1'b1, 4'hF, 8'h03, 32'h0000_00C3);
        step();
        drive_a(1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        step();
        drive_a(1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        step();
        drive_a(1'b1, 1'b0, 4'h0, 8'h03, 32'h0);
        step();
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        check("b2b_rv1", 64'(bus.a_rvalid), 64'(1'b1));
        check("b2b_d1",  64'(bus.a_rdata),  64'(32'hA1));
        step();
        check("b2b_rv2", 64'(bus.a_rvalid), 64'(1'b1));
        check("b2b_d2",  64'(bus.a_rdata),  64'(32'hB2));
        step();
        check("b2b_rv3", 64'(bus.a_rvalid), 64'(1'b1));
        check("b2b_d3",  64'(bus.a_rdata),  64'(32'hC3));
        step();
        check("b2b_rv_end", 64'(bus.a_rvalid), 64'(1'b0));
        check("b2b_hold",   64'(bus.a_rdata),  64'(32'hC3));

        // Write/read collision on 0x20
        drive_a(1'b1, 1'b1, 4'hF, 8'h20, 32'h55);
        drive_b(1'b1, 8'h20);
        #1;
        check("coll_b_ready", 64'(bus.b_ready), 64'(1'b0));
        check("coll_a_ready", 64'(bus.a_ready), 64'(1'b1));
        step();
        check("coll_csb1", 64'(csb1), 64'(1'b1));
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        #1;
        check("coll_b_ready2", 64'(bus.b_ready), 64'(1'b1));
        step();
        check("coll_b_pins", {55'h0, csb1, addr1}, {55'h0, 1'b0, 8'h20});
        drive_b(1'b0, 8'h00);
        step();
        check("coll_rv_t1", 64'(bus.b_rvalid), 64'(1'b0));
        step();
        check("coll_rv_t2", 64'(bus.b_rvalid), 64'(1'b1));
        check("coll_data",  64'(bus.b_rdata),  64'(32'h55));
        step();
        check("coll_rv_end", 64'(bus.b_rvalid), 64'(1'b0));
        check("coll_hold",   64'(bus.b_rdata),  64'(32'h55));

        // Read-after-write on B one edge later, then dual-port read
        drive_a(1'b1, 1'b1, 4'hF, 8'h30, 32'h3030_3030);
        step();
        drive_a(1'b1, 1'b1, 4'hF, 8'h31, 32'h3131_3131);
        drive_b(1'b1, 8'h30);
        #1;
        check("nocoll_b_ready", 64'(bus.b_ready), 64'(1'b1));
        step();
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b0, 8'h00);
        step();
        check("raw_rv_t1", 64'(bus.b_rvalid), 64'(1'b0));
        step();
        check("raw_rv_t2", 64'(bus.b_rvalid), 64'(1'b1));
        check("raw_data",  64'(bus.b_rdata),  64'(32'h3030_3030));
        drive_a(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        drive_b(1'b1, 8'h31);
        step();
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_b(1'b0, 8'h00);
        check("dual_b_rv_t0", 64'(bus.b_rvalid), 64'(1'b0));
        step();
        check("dual_rv_t1", 64'({bus.a_rvalid, bus.b_rvalid}), 64'(2'b00));
        step();
        check("dual_rv_t2", 64'({bus.a_rvalid, bus.b_rvalid}), 64'(2'b11));
        check("dual_a_data", 64'(bus.a_rdata), 64'(32'h3030_3030));
        check("dual_b_data", 64'(bus.b_rdata), 64'(32'h3131_3131));

        // Reset asserted right after a read accept
        drive_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        step();
        drive_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        rstn = 1'b0;
        #1;
        check("mid_rst_csb0",  64'(csb0),         64'(1'b1));
        check("mid_rst_addr0", 64'(addr0),        64'(8'h00));
        check("mid_rst_rv",    64'(bus.a_rvalid), 64'(1'b0));
        check("mid_rst_done",  64'(init_done),    64'(1'b0));
        step();
        step();
        check("mid_rst_rv2",   64'(bus.a_rvalid), 64'(1'b0));
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("reinit_write", {27'h0, csb0, web0, wmask0, addr0, din0},
                  {27'h0, 1'b0, 1'b0, 4'hF, 8'(i), 32'h0});
            check("reinit_rv", 64'(bus.a_rvalid), 64'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
